// File: rtl/alu_pkg.sv
// Shared opcode/funct encodings, controller state encoding and legal-op check
// for the shared-ALU controller and its ALU.
package alu_pkg;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h12;
  localparam logic [5:0] OP_ORI   = 6'h13;
  localparam logic [5:0] OP_LUI   = 6'h15;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LL    = 6'h30;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [5:0] opcode, input logic [5:0] funct);
    logic legal;
    legal = 1'b0;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
        FN_NOR, FN_SRA, FN_SRL, FN_SLL, FN_SLTU, FN_SLT: legal = 1'b1;
        default: legal = 1'b0;
      endcase
    end else begin
      case (opcode)
        OP_ADDI, OP_ADDIU, OP_ANDI, OP_BEQ, OP_BNE, OP_LUI, OP_ORI, OP_SLTI,
        OP_SLTIU, OP_SB, OP_SH, OP_SW, OP_LW, OP_LBU, OP_LHU, OP_LL: legal = 1'b1;
        default: legal = 1'b0;
      endcase
    end
    return legal;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// 32-bit ALU for the supported R-type and I-type subset. Loads/stores and ll
// produce the effective address rs + sign-extended imm. sig_branch is only
// meaningful for beq/bne; elsewhere it carries a raw equality compare and
// must be gated by the user.
module ALU32bit
  import alu_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  alu_control,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] alu_result,
  output logic        sig_branch
);

  logic [31:0] simm;
  logic [31:0] zimm;

  assign simm = {{16{imm[15]}}, imm};
  assign zimm = {16'h0000, imm};

  // Result and branch-compare selection by opcode, then funct for R-type
  always_comb begin
    alu_result = '0;
    sig_branch = (rs == rt);
    case (opcode)
      OP_RTYPE: begin
        case (alu_control)
          FN_ADD, FN_ADDU: alu_result = rs + rt;
          FN_SUB, FN_SUBU: alu_result = rs - rt;
          FN_AND:          alu_result = rs & rt;
          FN_OR:           alu_result = rs | rt;
          FN_NOR:          alu_result = ~(rs | rt);
          FN_SLL:          alu_result = rt << shamt;
          FN_SRL:          alu_result = rt >> shamt;
          FN_SRA:          alu_result = $unsigned($signed(rt) >>> shamt);
          FN_SLT:          alu_result = {31'd0, $signed(rs) < $signed(rt)};
          FN_SLTU:         alu_result = {31'd0, rs < rt};
          default:         alu_result = '0;
        endcase
      end
      OP_BEQ: begin
        alu_result = rs - rt;
        sig_branch = (rs == rt);
      end
      OP_BNE: begin
        alu_result = rs - rt;
        sig_branch = (rs != rt);
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW, OP_LL: alu_result = rs + simm;
      OP_ANDI:  alu_result = rs & zimm;
      OP_ORI:   alu_result = rs | zimm;
      OP_LUI:   alu_result = {imm, 16'h0000};
      OP_SLTI:  alu_result = {31'd0, $signed(rs) < $signed(simm)};
      OP_SLTIU: alu_result = {31'd0, rs < simm};
      default:  alu_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl_rr_arb.sv
// Round-robin arbiter: searches from ptr upward (wrapping) and grants the
// first asserted request. Purely combinational.
module rr_arb #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] idx,
  output logic            hit
);

  // First set request at or after ptr wins; later candidates are masked by hit
  always_comb begin
    int k;
    k     = 0;
    grant = '0;
    idx   = '0;
    hit   = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      k = int'(ptr) + off;
      if (k >= NREQ) k = k - NREQ;
      if (!hit && req[k]) begin
        hit      = 1'b1;
        grant[k] = 1'b1;
        idx      = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU32bit between NREQ requesters: round-robin grant, operand
// latch, one ALU cycle, then a registered valid/ready response.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  S_IDLE  | no op in flight; grant any pending request
//  S_ISSUE | latched operands drive the ALU; capture result at cycle end
//  S_HOLD  | response valid; on rsp_ready accept the next request or idle
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [6*NREQ-1:0] req_opcode,
  input  logic [6*NREQ-1:0] req_funct,
  input  logic [5*NREQ-1:0] req_shamt,
  input  logic [16*NREQ-1:0] req_imm,
  input  logic [32*NREQ-1:0] req_rs,
  input  logic [32*NREQ-1:0] req_rt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [31:0]       rsp_result,
  output logic              rsp_branch,
  output logic              rsp_illegal,
  output logic              busy
);

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] op_id;
  logic [5:0]      op_opcode;
  logic [5:0]      op_funct;
  logic [4:0]      op_shamt;
  logic [15:0]     op_imm;
  logic [31:0]     op_rs;
  logic [31:0]     op_rt;

  logic [NREQ-1:0] arb_grant;
  logic [ID_W-1:0] arb_idx;
  logic            arb_hit;
  logic            can_accept;
  logic            accept;
  logic [31:0]     alu_result;
  logic            alu_branch;
  logic            op_legal;
  logic            op_is_branch;

  rr_arb #(
    .NREQ(NREQ),
    .ID_W(ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .hit   (arb_hit)
  );

  ALU32bit u_alu (
    .opcode      (op_opcode),
    .alu_control (op_funct),
    .shamt       (op_shamt),
    .imm         (op_imm),
    .rs          (op_rs),
    .rt          (op_rt),
    .alu_result  (alu_result),
    .sig_branch  (alu_branch)
  );

  // Reset is folded in so req_ready reads 0 while reset is held
  assign can_accept   = !reset && ((state == S_IDLE) || (state == S_HOLD && rsp_ready));
  assign req_ready    = can_accept ? arb_grant : '0;
  assign accept       = can_accept && arb_hit;
  assign busy         = (state != S_IDLE);
  assign op_legal     = is_legal_op(op_opcode, op_funct);
  assign op_is_branch = (op_opcode == OP_BEQ) || (op_opcode == OP_BNE);

  // Sequencer: latch winner on accept, capture the ALU output, hold the response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      op_id       <= '0;
      op_opcode   <= '0;
      op_funct    <= '0;
      op_shamt    <= '0;
      op_imm      <= '0;
      op_rs       <= '0;
      op_rt       <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_result  <= '0;
      rsp_branch  <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      if (accept) begin
        op_id     <= arb_idx;
        op_opcode <= req_opcode[int'(arb_idx)*6 +: 6];
        op_funct  <= req_funct[int'(arb_idx)*6 +: 6];
        op_shamt  <= req_shamt[int'(arb_idx)*5 +: 5];
        op_imm    <= req_imm[int'(arb_idx)*16 +: 16];
        op_rs     <= req_rs[int'(arb_idx)*32 +: 32];
        op_rt     <= req_rt[int'(arb_idx)*32 +: 32];
        rr_ptr    <= (arb_idx == ID_W'(NREQ-1)) ? '0 : arb_idx + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (accept) state <= S_ISSUE;
        end
        S_ISSUE: begin
          rsp_valid   <= 1'b1;
          rsp_id      <= op_id;
          rsp_illegal <= !op_legal;
          rsp_result  <= op_legal ? alu_result : '0;
          rsp_branch  <= op_legal && op_is_branch && alu_branch;
          state       <= S_HOLD;
        end
        S_HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= accept ? S_ISSUE : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl with a behavioural ALU/arbiter model.
module tb_alu_share_ctrl;

  localparam int NREQ = 2;
  localparam int ID_W = 1;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [6*NREQ-1:0]  req_opcode;
  logic [6*NREQ-1:0]  req_funct;
  logic [5*NREQ-1:0]  req_shamt;
  logic [16*NREQ-1:0] req_imm;
  logic [32*NREQ-1:0] req_rs;
  logic [32*NREQ-1:0] req_rt;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [31:0]        rsp_result;
  logic               rsp_branch;
  logic               rsp_illegal;
  logic               busy;

  int errors = 0;
  int checks = 0;

  logic [5:0] legal_fn [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                6'h27, 6'h03, 6'h02, 6'h00, 6'h2B, 6'h2A};
  logic [5:0] legal_op [16] = '{6'h08, 6'h09, 6'h12, 6'h04, 6'h05, 6'h15, 6'h13, 6'h0A,
                                6'h0B, 6'h28, 6'h29, 6'h2B, 6'h23, 6'h24, 6'h25, 6'h30};

  always #5 clk = ~clk;

  alu_share_ctrl #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opcode  (req_opcode),
    .req_funct   (req_funct),
    .req_shamt   (req_shamt),
    .req_imm     (req_imm),
    .req_rs      (req_rs),
    .req_rt      (req_rt),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_branch  (rsp_branch),
    .rsp_illegal (rsp_illegal),
    .busy        (busy)
  );

  function automatic void model_op(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                   input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                                   output logic [31:0] res, output logic br, output logic ill);
    logic [31:0] se;
    bit ok;
    se = {{16{imm[15]}}, imm};
    ok = 0;
    if (op == 6'h00) begin
      foreach (legal_fn[j]) if (legal_fn[j] == fn) ok = 1;
    end else begin
      foreach (legal_op[j]) if (legal_op[j] == op) ok = 1;
    end
    res = 32'd0;
    br  = 1'b0;
    ill = !ok;
    if (!ok) return;
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: res = rs + rt;
        6'h22, 6'h23: res = rs - rt;
        6'h24: res = rs & rt;
        6'h25: res = rs | rt;
        6'h27: res = ~(rs | rt);
        6'h00: res = rt << sh;
        6'h02: res = rt >> sh;
        6'h03: res = rt[31] ? ~((~rt) >> sh) : (rt >> sh);
        6'h2A: res = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
        6'h2B: res = (rs < rt) ? 32'd1 : 32'd0;
        default: res = 32'd0;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09, 6'h28, 6'h29, 6'h2B, 6'h23, 6'h24, 6'h25, 6'h30: res = rs + se;
        6'h12: res = rs & {16'h0000, imm};
        6'h13: res = rs | {16'h0000, imm};
        6'h15: res = {imm, 16'h0000};
        6'h0A: res = ($signed(rs) < $signed(se)) ? 32'd1 : 32'd0;
        6'h0B: res = (rs < se) ? 32'd1 : 32'd0;
        6'h04: begin res = rs - rt; br = (rs == rt); end
        6'h05: begin res = rs - rt; br = (rs != rt); end
        default: res = 32'd0;
      endcase
    end
  endfunction

  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] mask);
    for (int off = 0; off < NREQ; off++)
      if (mask[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
    return -1;
  endfunction

  task automatic set_slot(input int i, input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                          input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt);
    req_opcode[6*i +: 6] = op;
    req_funct[6*i +: 6]  = fn;
    req_shamt[5*i +: 5]  = sh;
    req_imm[16*i +: 16]  = imm;
    req_rs[32*i +: 32]   = rs;
    req_rt[32*i +: 32]   = rt;
  endtask

  task automatic exp_slot(input int i, output logic [31:0] res, output logic br, output logic ill);
    model_op(req_opcode[6*i +: 6], req_funct[6*i +: 6], req_shamt[5*i +: 5],
             req_imm[16*i +: 16], req_rs[32*i +: 32], req_rt[32*i +: 32], res, br, ill);
  endtask

  task automatic rand_slot(input int i);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] rs;
    logic [31:0] rt;
    int r;
    r  = $urandom_range(0, 9);
    rs = $urandom;
    rt = (r % 3 == 0) ? rs : $urandom;
    op = 6'h00;
    fn = legal_fn[$urandom_range(0, 11)];
    if (r >= 4 && r <= 8) op = legal_op[$urandom_range(0, 15)];
    else if (r == 9) begin
      op = 6'($urandom);
      fn = 6'($urandom);
    end
    set_slot(i, op, fn, 5'($urandom), 16'($urandom), rs, rt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One op from a single requester, starting at a negedge in IDLE
  task automatic run_single(input int slot, output logic [NREQ-1:0] rdy, output int lat,
                            output logic [31:0] res, output logic br, output logic ill,
                            output logic [ID_W-1:0] id, output logic post_valid, output logic post_busy);
    req_valid = NREQ'(1 << slot);
    rsp_ready = 1'b0;
    #1 rdy = req_ready;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    lat = 0;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) lat = -1;
    res = rsp_result;
    br  = rsp_branch;
    ill = rsp_illegal;
    id  = rsp_id;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    post_valid = rsp_valid;
    post_busy  = busy;
    rsp_ready  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) rand_slot(i);
    req_valid = '1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_branch, rsp_illegal, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b id=%h result=%h branch=%b illegal=%b busy=%b required all 0",
               rsp_valid, rsp_id, rsp_result, rsp_branch, rsp_illegal, busy);
    end
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL reset_req_ready got=%b required=0", req_ready);
    end
    reset = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle got busy=%b valid=%b required 0/0", busy, rsp_valid);
    end
  endtask

  task automatic test_single_add();
    set_slot(0, 6'h00, 6'h20, 5'd0, 16'h0000, 32'd5, 32'd7);
    rand_slot(1);
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL add_grant got=%b required=01", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== '0) begin
      errors++;
      $display("FAIL add_issue got valid=%b busy=%b ready=%b required 0/1/00", rsp_valid, busy, req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd12 || rsp_id !== 1'b0 || rsp_branch !== 1'b0 || rsp_illegal !== 1'b0) begin
      errors++;
      $display("FAIL add_resp got valid=%b result=%h id=%h branch=%b illegal=%b required 1/0000000c/0/0/0",
               rsp_valid, rsp_result, rsp_id, rsp_branch, rsp_illegal);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL add_done got valid=%b busy=%b required 0/0", rsp_valid, busy);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_contention();
    int ptr;
    int g;
    logic [31:0] er;
    logic eb;
    logic ei;
    do_reset();
    ptr = 0;
    rand_slot(0);
    rand_slot(1);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      g = rr_pick(ptr, req_valid);
      exp_slot(g, er, eb, ei);
      checks++;
      if (req_ready !== NREQ'(1 << g)) begin
        errors++;
        $display("FAIL contend_grant%0d got=%b required=%b", k, req_ready, NREQ'(1 << g));
      end
      @(posedge clk);
      ptr = (g + 1) % NREQ;
      @(negedge clk);
      checks++;
      if (req_ready !== '0 || rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL contend_issue%0d got ready=%b valid=%b required 00/0", k, req_ready, rsp_valid);
      end
      rand_slot(g);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(k % 2) || rsp_result !== er || rsp_branch !== eb || rsp_illegal !== ei) begin
        errors++;
        $display("FAIL contend_resp%0d got valid=%b id=%h result=%h br=%b ill=%b required 1/%h/%h/%b/%b",
                 k, rsp_valid, rsp_id, rsp_result, rsp_branch, rsp_illegal, ID_W'(k % 2), er, eb, ei);
      end
    end
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL contend_idle got busy=%b valid=%b required 0/0", busy, rsp_valid);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] er;
    logic eb;
    logic ei;
    rand_slot(0);
    rand_slot(1);
    exp_slot(0, er, eb, ei);
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b11;
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== er || rsp_branch !== eb || rsp_illegal !== ei ||
          rsp_id !== 1'b0 || req_ready !== '0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d got valid=%b result=%h br=%b ill=%b id=%h ready=%b busy=%b required 1/%h/%b/%b/0/00/1",
                 c, rsp_valid, rsp_result, rsp_branch, rsp_illegal, rsp_id, req_ready, busy, er, eb, ei);
      end
      @(posedge clk);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL bp_same_cycle_grant got=%b required=10", req_ready);
    end
    exp_slot(1, er, eb, ei);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drop_after_handshake got valid=%b required=0", rsp_valid);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== er || rsp_branch !== eb || rsp_illegal !== ei) begin
      errors++;
      $display("FAIL bp_second_resp got valid=%b id=%h result=%h br=%b ill=%b required 1/1/%h/%b/%b",
               rsp_valid, rsp_id, rsp_result, rsp_branch, rsp_illegal, er, eb, ei);
    end
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_branch();
    int s;
    int lat;
    logic [NREQ-1:0] rdy;
    logic [31:0] res;
    logic [31:0] er;
    logic br, ill, eb, ei, pv, pb;
    logic [ID_W-1:0] id;
    for (int i = 0; i < 7; i++) begin
      s = i % 2;
      case (i)
        0: set_slot(s, 6'h04, 6'h00, 5'd0, 16'h0000, 32'd9, 32'd9);
        1: set_slot(s, 6'h08, 6'h00, 5'd0, 16'hFFFF, 32'd1, 32'd0);
        2: set_slot(s, 6'h05, 6'h00, 5'd0, 16'h0000, 32'd9, 32'd9);
        3: set_slot(s, 6'h05, 6'h00, 5'd0, 16'h0000, 32'd3, 32'd4);
        4: set_slot(s, 6'h04, 6'h00, 5'd0, 16'h0000, 32'd3, 32'd4);
        5: set_slot(s, 6'h00, 6'h20, 5'd0, 16'h0000, 32'd5, 32'd5);
        default: set_slot(s, 6'h2B, 6'h00, 5'd0, 16'h0010, 32'h100, 32'h100);
      endcase
      exp_slot(s, er, eb, ei);
      run_single(s, rdy, lat, res, br, ill, id, pv, pb);
      checks++;
      if (rdy !== NREQ'(1 << s) || lat !== 1) begin
        errors++;
        $display("FAIL br_grant%0d got ready=%b lat=%0d required %b/1", i, rdy, lat, NREQ'(1 << s));
      end
      checks++;
      if (res !== er || br !== eb || ill !== ei || id !== ID_W'(s)) begin
        errors++;
        $display("FAIL br_resp%0d got result=%h br=%b ill=%b id=%h required %h/%b/%b/%h",
                 i, res, br, ill, id, er, eb, ei, ID_W'(s));
      end
    end
  endtask

  task automatic test_illegal();
    int lat;
    logic [NREQ-1:0] rdy;
    logic [31:0] res;
    logic br, ill, pv, pb;
    logic [ID_W-1:0] id;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: set_slot(0, 6'h3F, 6'h20, 5'd0, 16'h1234, 32'd9, 32'd9);
        1: set_slot(0, 6'h00, 6'h3F, 5'd3, 16'h0000, 32'd7, 32'd7);
        2: set_slot(0, 6'h0C, 6'h00, 5'd0, 16'h00FF, 32'd4, 32'd4);
        default: set_slot(0, 6'h00, 6'h26, 5'd0, 16'h0000, 32'hA5A5_0000, 32'hA5A5_0000);
      endcase
      run_single(0, rdy, lat, res, br, ill, id, pv, pb);
      checks++;
      if (ill !== 1'b1 || res !== 32'd0 || br !== 1'b0 || lat !== 1) begin
        errors++;
        $display("FAIL illegal_resp%0d got ill=%b result=%h br=%b lat=%0d required 1/00000000/0/1",
                 i, ill, res, br, lat);
      end
      checks++;
      if (pv !== 1'b0 || pb !== 1'b0) begin
        errors++;
        $display("FAIL illegal_handshake%0d got valid=%b busy=%b required 0/0", i, pv, pb);
      end
    end
  endtask

  task automatic test_random();
    int ptr;
    int g;
    int stall;
    logic [NREQ-1:0] mask;
    logic [31:0] er;
    logic eb;
    logic ei;
    do_reset();
    ptr = 0;
    for (int i = 0; i < NREQ; i++) rand_slot(i);
    for (int k = 0; k < 24; k++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      req_valid = mask;
      rsp_ready = 1'b1;
      #1;
      g = rr_pick(ptr, mask);
      exp_slot(g, er, eb, ei);
      checks++;
      if (req_ready !== NREQ'(1 << g)) begin
        errors++;
        $display("FAIL rand_grant%0d got=%b required=%b", k, req_ready, NREQ'(1 << g));
      end
      @(posedge clk);
      ptr = (g + 1) % NREQ;
      @(negedge clk);
      req_valid = '0;
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== '0) begin
        errors++;
        $display("FAIL rand_issue%0d got valid=%b ready=%b required 0/00", k, rsp_valid, req_ready);
      end
      for (int i = 0; i < NREQ; i++) rand_slot(i);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_branch, rsp_illegal} !== {1'b1, ID_W'(g), er, eb, ei}) begin
        errors++;
        $display("FAIL rand_resp%0d got valid=%b id=%h result=%h br=%b ill=%b required 1/%h/%h/%b/%b",
                 k, rsp_valid, rsp_id, rsp_result, rsp_branch, rsp_illegal, ID_W'(g), er, eb, ei);
      end
      stall = $urandom_range(0, 2);
      repeat (stall) begin
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, ID_W'(g), er} || req_ready !== '0) begin
          errors++;
          $display("FAIL rand_stall%0d got valid=%b id=%h result=%h ready=%b required 1/%h/%h/00",
                   k, rsp_valid, rsp_id, rsp_result, req_ready, ID_W'(g), er);
        end
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain got valid=%b busy=%b required 0/0", rsp_valid, busy);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    rand_slot(0);
    rand_slot(1);
    set_slot(0, 6'h00, 6'h25, 5'd0, 16'h0000, 32'hF0F0_0000, 32'h0000_0F0F);
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'hF0F0_0F0F) begin
      errors++;
      $display("FAIL rst_mid_precond got valid=%b result=%h required 1/f0f00f0f", rsp_valid, rsp_result);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_branch, rsp_illegal, busy} !== '0 || req_ready !== '0) begin
      errors++;
      $display("FAIL rst_mid_async got valid=%b id=%h result=%h br=%b ill=%b busy=%b ready=%b required all 0",
               rsp_valid, rsp_id, rsp_result, rsp_branch, rsp_illegal, busy, req_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rst_mid_next_grant got=%b required=01", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_next_resp got valid=%b id=%h required 1/0", rsp_valid, rsp_id);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    rsp_ready  = 1'b0;
    req_opcode = '0;
    req_funct  = '0;
    req_shamt  = '0;
    req_imm    = '0;
    req_rs     = '0;
    req_rt     = '0;
    test_reset();
    test_single_add();
    test_contention();
    test_backpressure();
    test_branch();
    test_illegal();
    test_random();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
